// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Two-entry elastic pipeline stage (main + skid) with
//                registered outputs, registered ready, flush and a
//                saturating backpressure-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int                  DATA_W   = 32,
    parameter int                  CTRL_W   = 4,
    parameter logic [CTRL_W-1:0]   CTRL_NOP = '0,
    parameter int                  CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Occupancy encoding: EMPTY (nothing), ONE (main valid), FULL (main+skid)
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]        r_state;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Ready comes straight from the occupancy register so upstream never
    // sees a combinational path from downstream ready or its own valid.
    assign w_in_ready = (r_state != c_ST_FULL);
    assign w_in_xfer  = in_valid_i && w_in_ready;
    assign w_out_xfer = r_out_valid && out_ready_i;

    // Occupancy and entry storage; reset beats flush, flush beats transfers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= CTRL_NOP;
            r_out_data  <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (flush_i) begin
            // Payload registers keep their contents; only validity is dropped.
            r_state     <= c_ST_EMPTY;
            r_out_valid <= 1'b0;
            r_out_ctrl  <= CTRL_NOP;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= c_ST_ONE;
                        r_out_valid <= 1'b1;
                        r_out_ctrl  <= in_ctrl_i;
                        r_out_data  <= in_data_i;
                    end
                end
                c_ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out_ctrl <= in_ctrl_i;
                        r_out_data <= in_data_i;
                    end else if (w_in_xfer) begin
                        r_state     <= c_ST_FULL;
                        r_skid_ctrl <= in_ctrl_i;
                        r_skid_data <= in_data_i;
                    end else if (w_out_xfer) begin
                        r_state     <= c_ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_out_ctrl  <= CTRL_NOP;
                    end
                end
                c_ST_FULL: begin
                    if (w_out_xfer) begin
                        r_state    <= c_ST_ONE;
                        r_out_ctrl <= r_skid_ctrl;
                        r_out_data <= r_skid_data;
                    end
                end
                default: begin
                    r_state     <= c_ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_out_ctrl  <= CTRL_NOP;
                end
            endcase
        end
    end

    // Count cycles where an entry waits on downstream; saturates, survives flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready_i && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign out_ctrl_o  = r_out_ctrl;
    assign out_data_o  = r_out_data;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_stage
//  Description : Self-checking bench for pipe_skid_stage against a queue
//                based 2-deep FIFO reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;

    localparam int          DATA_W = 32;
    localparam int          CTRL_W = 4;
    localparam logic [3:0]  NOP    = 4'hA;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       stall_cnt;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [2:0]        s_stall_cnt;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (NOP),
        .CNT_W    (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (out_ctrl),
        .out_data_o  (out_data),
        .stall_cnt_o (stall_cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    pipe_skid_stage #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (NOP),
        .CNT_W    (3)
    ) dut_s (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (s_in_ready),
        .in_ctrl_i   (in_ctrl),
        .in_data_i   (in_data),
        .flush_i     (flush),
        .out_valid_o (s_out_valid),
        .out_ready_i (out_ready),
        .out_ctrl_o  (s_out_ctrl),
        .out_data_o  (s_out_data),
        .stall_cnt_o (s_stall_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: entries held by the stage, oldest first.
    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];
    longint            stall_m   = 0;
    logic [DATA_W-1:0] last_data = '0;

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic compare_all();
        logic [CTRL_W-1:0] exp_ctrl;
        exp_ctrl = NOP;
        if (q_ctrl.size() > 0) exp_ctrl = q_ctrl[0];
        check_eq("out_valid",   out_valid,   q_data.size() > 0);
        check_eq("in_ready",    in_ready,    q_data.size() < 2);
        check_eq("out_ctrl",    out_ctrl,    exp_ctrl);
        check_eq("out_data",    out_data,    last_data);
        check_eq("stall_cnt",   stall_cnt,   sat(stall_m, 65535));
        check_eq("s_stall_cnt", s_stall_cnt, sat(stall_m, 7));
        check_eq("s_out_data",  s_out_data,  last_data);
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl, input logic rs);
        bit ox, ix;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = rs;
        @(posedge clk);
        if (rs) begin
            q_data.delete();
            q_ctrl.delete();
            stall_m   = 0;
            last_data = '0;
        end else begin
            if (q_data.size() > 0 && !ordy) stall_m++;
            if (fl) begin
                q_data.delete();
                q_ctrl.delete();
            end else begin
                ox = (q_data.size() > 0) && ordy;
                ix = v && (q_data.size() < 2);
                if (ox) begin
                    void'(q_data.pop_front());
                    void'(q_ctrl.pop_front());
                end
                if (ix) begin
                    q_data.push_back(d);
                    q_ctrl.push_back(c);
                end
            end
            if (q_data.size() > 0) last_data = q_data[0];
        end
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset state
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_ctrl",  out_ctrl,  4'hA);
        check_eq("rst_out_data",  out_data,  0);
        check_eq("rst_in_ready",  in_ready,  1);
        check_eq("rst_stall",     stall_cnt, 0);

        // Back-to-back stream, one-cycle latency
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 4'(i), 32'(i), 1'b1, 1'b0, 1'b0);
            check_eq("stream_data",  out_data, i);
            check_eq("stream_ready", in_ready, 1);
        end
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_eq("stream_stall", stall_cnt, 0);

        // Backpressure fills skid, then drains in order
        cycle(1'b1, 4'h1, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 32'hB, 1'b0, 1'b0, 1'b0);
        check_eq("bp_ready_low", in_ready, 0);
        check_eq("bp_hold_a",    out_data, 32'hA);
        cycle(1'b1, 4'h3, 32'hD, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check_eq("bp_drain_b",   out_data, 32'hB);
        check_eq("bp_ready_back", in_ready, 1);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with a new entry presented
        cycle(1'b1, 4'h3, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 32'h2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h5, 32'hC, 1'b0, 1'b1, 1'b0);
        check_eq("fl_valid", out_valid, 0);
        check_eq("fl_ctrl",  out_ctrl,  4'hA);
        check_eq("fl_ready", in_ready,  1);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Saturation of the narrow counter
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'h6, 32'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("sat_s_stall", s_stall_cnt, 7);
        check_eq("sat_stall",   stall_cnt,   10);

        // Reset while FULL with five stalled cycles
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 4'h1, 32'hA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 32'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_stall", stall_cnt, 5);
        check_eq("pre_rst_full",  in_ready,  0);
        cycle(1'b1, 4'h3, 32'h5, 1'b1, 1'b1, 1'b1);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data",  out_data,  0);
        check_eq("mid_rst_stall", stall_cnt, 0);
        check_eq("mid_rst_ready", in_ready,  1);

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            cycle($urandom_range(0, 3) != 0, 4'($urandom), 32'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
